// File: rtl/fnd_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter feeding the FND scan controller.
// Define FND_BCD_LEADING_BLANK_EN to replace leading zero digits with BLANK_CODE.
module fnd_bcd_converter #(
  parameter int          BIN_WIDTH  = 14,
  parameter logic [3:0]  BLANK_CODE = 4'hF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          bcd,
  output logic                 overflow
);

  localparam int SW = 16 + BIN_WIDTH;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t          state;
  logic [SW-1:0]   sr;
  logic [SW-1:0]   sr_nxt;
  logic [CW-1:0]   cnt;
  logic            ovf_pending;
  logic [15:0]     adj;
  logic            bin_ovf;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

`ifdef FND_BCD_LEADING_BLANK_EN
  function automatic logic [15:0] fmt(input logic [15:0] v);
    logic [15:0] r;
    logic        lead;
    r    = v;
    lead = 1'b1;
    for (int i = 3; i > 0; i--) begin
      if (lead && v[i*4+:4] == 4'h0)
        r[i*4+:4] = BLANK_CODE;
      else
        lead = 1'b0;
    end
    return r;
  endfunction
`else
  logic unused_blank;
  assign unused_blank = ^BLANK_CODE;

  function automatic logic [15:0] fmt(input logic [15:0] v);
    return v;
  endfunction
`endif

  // Folds to constant 0 when BIN_WIDTH cannot reach 10000.
  assign bin_ovf = 32'(bin) > 32'd9999;

  always_comb begin
    adj = '0;
    for (int d = 0; d < 4; d++)
      adj[d*4+:4] = add3(sr[BIN_WIDTH+d*4+:4]);
    sr_nxt = {adj[14:0], sr[BIN_WIDTH-1:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd         <= 16'h0000;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr          <= SW'(bin);
            ovf_pending <= bin_ovf;
            cnt         <= CW'(BIN_WIDTH);
            busy        <= 1'b1;
            state       <= CONV;
          end
        end
        CONV: begin
          sr  <= sr_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            overflow <= ovf_pending;
            bcd      <= ovf_pending ? 16'h9999
                      : fmt(sr_nxt[SW-1:BIN_WIDTH]);
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fnd_bcd_converter.sv
// Directed bench for fnd_bcd_converter with a queue-based result scoreboard.
module tb_fnd_bcd_converter;

  localparam int W = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  bin;
  logic          busy;
  logic          done;
  logic [15:0]   bcd;
  logic          overflow;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  logic [16:0]   q[$];

  fnd_bcd_converter #(
    .BIN_WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bin(bin),
    .busy(busy),
    .done(done),
    .bcd(bcd),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  function automatic logic [16:0] model(input int v);
    logic [15:0] r;
    if (v > 9999) return {1'b1, 16'h9999};
    r = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
`ifdef FND_BCD_LEADING_BLANK_EN
    if (r[15:12] == 4'h0) begin
      r[15:12] = 4'hF;
      if (r[11:8] == 4'h0) begin
        r[11:8] = 4'hF;
        if (r[7:4] == 4'h0) r[7:4] = 4'hF;
      end
    end
`endif
    return {1'b0, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic launch(input int v);
    start = 1'b1;
    bin   = W'(v);
    q.push_back(model(v));
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int bcyc, output int dcyc);
    logic        got;
    logic [16:0] e;
    got  = 1'b0;
    bcyc = 0;
    dcyc = -1;
    for (int i = 0; i < 64 && !got; i++) begin
      if (done === 1'b1) begin
        got  = 1'b1;
        dcyc = cyc;
      end else begin
        if (busy === 1'b1) bcyc++;
        tick();
      end
    end
    chk({tag, " done seen"}, 32'(got), 32'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      if (got) begin
        chk({tag, " bcd"}, 32'(bcd), 32'(e[15:0]));
        chk({tag, " ovf"}, 32'(overflow), 32'(e[16]));
        chk({tag, " busy low"}, 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    int bc;
    int d0;
    int d1;
    int dn;
    logic [16:0] e;

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    tick();
    tick();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst bcd", 32'(bcd), 32'h0);
    chk("rst ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();

    launch(1234);
    wait_done("t1234", bc, d0);
    chk("t1234 busy cycles", 32'(bc), 32'(W));
    tick();
    chk("t1234 pulse width", 32'(done), 32'd0);
    repeat (20) tick();
    e = model(1234);
    chk("t1234 hold bcd", 32'(bcd), 32'(e[15:0]));
    chk("t1234 hold ovf", 32'(overflow), 32'd0);

    launch(0);
    wait_done("t0", bc, d0);
    tick();
    launch(9999);
    wait_done("t9999", bc, d1);
    chk("b2b spacing", 32'(d1 - d0), 32'd16);

    tick();
    launch(10000);
    wait_done("t10000", bc, d0);
    tick();
    launch(16383);
    wait_done("t16383", bc, d0);
    tick();
    launch(7);
    wait_done("t7", bc, d0);

    tick();
    dn    = done_cnt;
    start = 1'b1;
    bin   = W'(4321);
    q.push_back(model(4321));
    tick();
    bin = W'(1111);
    wait_done("hold4321", bc, d0);
    q.push_back(model(1111));
    tick();
    chk("hold no accept in done", 32'(busy), 32'd0);
    tick();
    chk("hold accept from idle", 32'(busy), 32'd1);
    chk("hold single done", 32'(done_cnt - dn), 32'd1);
    start = 1'b0;
    wait_done("hold1111", bc, d0);

    tick();
    start = 1'b1;
    bin   = W'(5678);
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort bcd", 32'(bcd), 32'h0);
    chk("abort ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    dn  = done_cnt;
    repeat (20) tick();
    chk("abort no done", 32'(done_cnt - dn), 32'd0);
    launch(42);
    wait_done("t42", bc, d0);

    tick();
    launch(1005);
    wait_done("t1005", bc, d0);
    tick();
    launch(12000);
    wait_done("t12000", bc, d0);
    tick();
    launch(90);
    wait_done("t90", bc, d0);
    for (int k = 0; k < 4; k++) begin
      tick();
      launch(int'($urandom_range(0, 16383)));
      wait_done("rand", bc, d0);
    end

    repeat (3) tick();
    chk("scoreboard empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
